result_bcd_conv: RTL

- Downstream stage of the calculator's arithmetic units (factorial and peers).
- Takes a signed two's-complement result plus an overflow flag.
- Produces sign, unsigned BCD digits and a leading-zero blank mask for the 7-segment display driver.
- Uses iterative double-dabble: one shift per clock, no divider.

---
 rtl/result_bcd_conv_pkg.sv | 19 +
 rtl/result_bcd_conv_if.sv | 30 +++
 rtl/result_bcd_conv_add3.sv | 12 +
 rtl/result_bcd_conv.sv | 132 +++++++++++++
 4 files changed

// File: rtl/result_bcd_conv_pkg.sv
// Shared calculator constants: datapath widths and converter state encoding.
// Imported by the BCD result converter, its interface and its sub-module.
package calc_pkg;

  localparam int CALC_W      = 28;
  localparam int CALC_DIGITS = 9;
  localparam int BCD_W       = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/result_bcd_conv_if.sv
// Handshake bundle between an arithmetic unit and the BCD converter.
// master: d_in/ovrflow_in/valid_in out; slave: ready/valid_out/neg/err/bcd/blank out.
interface result_bcd_conv_if
  import calc_pkg::*;
#(
  parameter int W      = CALC_W,
  parameter int DIGITS = CALC_DIGITS
);

  logic [W-1:0]            d_in;
  logic                    ovrflow_in;
  logic                    valid_in;
  logic                    ready;
  logic                    valid_out;
  logic                    neg;
  logic                    err;
  logic [BCD_W*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]       blank;

  modport master (
    output d_in, ovrflow_in, valid_in,
    input  ready, valid_out, neg, err, bcd, blank
  );

  modport slave (
    input  d_in, ovrflow_in, valid_in,
    output ready, valid_out, neg, err, bcd, blank
  );

endinterface

// File: rtl/result_bcd_conv_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit >= 5.
// Ports: d (digit in), q (corrected digit out).
module bcd_add3
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  assign q = (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;

endmodule

// File: rtl/result_bcd_conv.sv
// Signed result to sign + BCD + leading-zero mask, one double-dabble shift per clock.
// Ports: clk, rst (sync, active-high), bus (slave side of result_bcd_conv_if).
module result_bcd_conv
  import calc_pkg::*;
#(
  parameter int W      = CALC_W,
  parameter int DIGITS = CALC_DIGITS
) (
  input logic               clk,
  input logic               rst,
  result_bcd_conv_if.slave  bus
);

  localparam int SW    = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      mag_q, mag_d;
  logic [SW-1:0]     scr_q, scr_d;
  logic              neg_p_q, neg_p_d;
  logic              err_p_q, err_p_d;
  logic              valid_out_q, valid_out_d;
  logic              neg_q, neg_d;
  logic              err_q, err_d;
  logic [SW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;

  logic [SW-1:0]     adj;
  logic [DIGITS-1:0] blank_c;
  logic              run;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scr_q[g*BCD_W +: BCD_W]),
      .q (adj[g*BCD_W +: BCD_W])
    );
  end

  // A digit is blank while it and every digit above it is zero.
  always_comb begin
    run     = 1'b1;
    blank_c = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run        = run & (scr_q[i*BCD_W +: BCD_W] == '0);
      blank_c[i] = run;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    scr_d       = scr_q;
    neg_p_d     = neg_p_q;
    err_p_d     = err_p_q;
    valid_out_d = 1'b0;
    neg_d       = neg_q;
    err_d       = err_q;
    bcd_d       = bcd_q;
    blank_d     = blank_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          scr_d = '0;
          cnt_d = '0;
          if (bus.ovrflow_in) begin
            err_p_d = 1'b1;
            neg_p_d = 1'b0;
            state_d = DONE;
          end else begin
            // -2^(W-1) negates to itself, which read unsigned is 2^(W-1).
            mag_d   = bus.d_in[W-1] ? -bus.d_in : bus.d_in;
            neg_p_d = bus.d_in[W-1];
            err_p_d = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        {scr_d, mag_d} = {adj, mag_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) state_d = DONE;
      end
      DONE: begin
        valid_out_d = 1'b1;
        bcd_d       = scr_q;
        neg_d       = neg_p_q;
        err_d       = err_p_q;
        blank_d     = blank_c;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      scr_q       <= '0;
      neg_p_q     <= 1'b0;
      err_p_q     <= 1'b0;
      valid_out_q <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      bcd_q       <= '0;
      blank_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      scr_q       <= scr_d;
      neg_p_q     <= neg_p_d;
      err_p_q     <= err_p_d;
      valid_out_q <= valid_out_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
      bcd_q       <= bcd_d;
      blank_q     <= blank_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.valid_out = valid_out_q;
  assign bus.neg       = neg_q;
  assign bus.err       = err_q;
  assign bus.bcd       = bcd_q;
  assign bus.blank     = blank_q;

endmodule
